// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the two-requester data-RAM arbiter:
//   - arb_state_e       : FSM state encodings (IDLE / ACCESS_A / ACCESS_B)
//   - RAM_WORDS_DEFAULT : default RAM depth in 16-bit words
//   - addr_limit()      : first out-of-range byte address for a given depth
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS_A = 2'd1,
    ACCESS_B = 2'd2
  } arb_state_e;

  localparam int unsigned RAM_WORDS_DEFAULT = 256;

  // Byte addresses at or above this value fall outside the RAM.
  function automatic int unsigned addr_limit(input int unsigned words);
    return 2 * words;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// One requester's request/acknowledge bus to the RAM arbiter.
//   request       : access requested, held until ack
//   write_enable  : 1 = write, 0 = read
//   address       : byte address
//   write_data    : data to write
//   read_data     : read result, valid with ack and held afterwards
//   ack           : one-cycle completion pulse
//   error         : high with ack when the address was out of range
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
);

  logic                     request;
  logic                     write_enable;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     ack;
  logic                     error;

  modport master (
    output request, write_enable, address, write_data,
    input  read_data, ack, error
  );

  modport slave (
    input  request, write_enable, address, write_data,
    output read_data, ack, error
  );

endinterface

// File: rtl/ram_arbiter_response.sv
// ram_arbiter_response
// Response registers for one requester of the RAM arbiter.
//   clock, reset     : system clock, synchronous active-low reset
//   done_i           : this requester's access is in its final cycle
//   in_range_i       : latched address of that access lies inside the RAM
//   ram_read_data_i  : combinational RAM read data
//   read_data_o      : captured read data, held until the next ack
//   ack_o, error_o   : one-cycle completion / out-of-range pulses
module ram_arbiter_response #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  done_i,
  input  logic                  in_range_i,
  input  logic [DATA_WIDTH-1:0] ram_read_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  ack_o,
  output logic                  error_o
);

  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  ack_q;
  logic                  error_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      read_data_q <= '0;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      ack_q   <= done_i;
      error_q <= done_i & ~in_range_i;
      // Captured for writes too; an out-of-range access reads back as zero.
      if (done_i) begin
        read_data_q <= in_range_i ? ram_read_data_i : '0;
      end
    end
  end

  assign read_data_o = read_data_q;
  assign ack_o       = ack_q;
  assign error_o     = error_q;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter giving two requesters (A: CPU load/store, B: loader/
// debug) shared access to a single-port 256 x 16 data RAM with combinational
// read. Each access takes one ACCESS cycle; ack follows in the next cycle.
//   clock, reset       : system clock, synchronous active-low reset
//   a, b               : requester buses (ram_arbiter_if.slave)
//   ram_write_enable   : RAM write strobe, forced low while reset=0
//   ram_address        : byte address to RAM (RAM ignores bit 0)
//   ram_write_data     : data to RAM
//   ram_read_data      : combinational RAM read data
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int          DATA_WIDTH    = 16,
  parameter int          ADDRESS_WIDTH = 16,
  parameter int unsigned RAM_WORDS     = RAM_WORDS_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  ram_arbiter_if.slave             a,
  ram_arbiter_if.slave             b,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  input  logic [DATA_WIDTH-1:0]    ram_read_data
);

  localparam int unsigned ADDR_LIMIT = addr_limit(RAM_WORDS);

  arb_state_e               state_q;
  logic                     ptr_b_q;     // 1 = B wins a tie
  logic                     lat_we_q;
  logic [ADDRESS_WIDTH-1:0] lat_addr_q;
  logic [DATA_WIDTH-1:0]    lat_wdata_q;

  logic a_elig;
  logic b_elig;
  logic grant_a;
  logic in_range;
  logic in_access;
  logic done_a;
  logic done_b;

  // A request seen during its own ack cycle is the tail of the access just
  // served, so it is not eligible again until the following cycle.
  assign a_elig  = a.request & ~a.ack;
  assign b_elig  = b.request & ~b.ack;
  assign grant_a = a_elig & (~b_elig | ~ptr_b_q);

  assign in_range  = (32'(lat_addr_q) < ADDR_LIMIT);
  assign done_a    = (state_q == ACCESS_A);
  assign done_b    = (state_q == ACCESS_B);
  assign in_access = done_a | done_b;

  // The reset term abandons a write in flight rather than committing it.
  assign ram_write_enable = in_access & lat_we_q & in_range & reset;
  assign ram_address      = lat_addr_q;
  assign ram_write_data   = lat_wdata_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_b_q     <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_a) begin
            lat_we_q    <= a.write_enable;
            lat_addr_q  <= a.address;
            lat_wdata_q <= a.write_data;
            state_q     <= ACCESS_A;
          end else if (b_elig) begin
            lat_we_q    <= b.write_enable;
            lat_addr_q  <= b.address;
            lat_wdata_q <= b.write_data;
            state_q     <= ACCESS_B;
          end
        end
        ACCESS_A: begin
          ptr_b_q <= 1'b1;
          state_q <= IDLE;
        end
        ACCESS_B: begin
          ptr_b_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_arbiter_response #(.DATA_WIDTH(DATA_WIDTH)) u_resp_a (
    .clock           (clock),
    .reset           (reset),
    .done_i          (done_a),
    .in_range_i      (in_range),
    .ram_read_data_i (ram_read_data),
    .read_data_o     (a.read_data),
    .ack_o           (a.ack),
    .error_o         (a.error)
  );

  ram_arbiter_response #(.DATA_WIDTH(DATA_WIDTH)) u_resp_b (
    .clock           (clock),
    .reset           (reset),
    .done_i          (done_b),
    .in_range_i      (in_range),
    .ram_read_data_i (ram_read_data),
    .read_data_o     (b.read_data),
    .ack_o           (b.ack),
    .error_o         (b.error)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural 256 x 16 RAM.
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        ram_write_enable;
  logic [15:0] ram_address;
  logic [15:0] ram_write_data;
  logic [15:0] ram_read_data;

  logic [15:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [15:0] pre_data;

  int tests;
  int fails;

  ram_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) a_bus ();
  ram_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) b_bus ();

  ram_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .RAM_WORDS(256)) dut (
    .clock            (clock),
    .reset            (reset),
    .a                (a_bus),
    .b                (b_bus),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: combinational read, write on rising edge, word = addr[8:1].
  assign ram_read_data = mem[ram_address[8:1]];
  always @(posedge clock) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_write_enable) mem[ram_address[8:1]] <= ram_write_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [15:0] data);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic req_a(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    a_bus.request      = 1'b1;
    a_bus.write_enable = we;
    a_bus.address      = addr;
    a_bus.write_data   = wd;
  endtask

  task automatic req_b(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    b_bus.request      = 1'b1;
    b_bus.write_enable = we;
    b_bus.address      = addr;
    b_bus.write_data   = wd;
  endtask

  logic [7:0] a_pat;
  logic [7:0] b_pat;

  initial begin
    tests = 0;
    fails = 0;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_data = '0;
    a_bus.request = 1'b0; a_bus.write_enable = 1'b0; a_bus.address = '0; a_bus.write_data = '0;
    b_bus.request = 1'b0; b_bus.write_enable = 1'b0; b_bus.address = '0; b_bus.write_data = '0;
    reset = 1'b0;

    // Reset held while the RAM is preloaded.
    preload(8'd0,  16'h0F0F);
    preload(8'd2,  16'hBEEF);
    preload(8'd8,  16'hAAAA);
    preload(8'd16, 16'h7777);
    reset = 1'b1;
    tick();
    check("rst_a_ack",   32'(a_bus.ack), 32'd0);
    check("rst_a_err",   32'(a_bus.error), 32'd0);
    check("rst_a_rdata", 32'(a_bus.read_data), 32'd0);
    check("rst_b_ack",   32'(b_bus.ack), 32'd0);
    check("rst_b_err",   32'(b_bus.error), 32'd0);
    check("rst_b_rdata", 32'(b_bus.read_data), 32'd0);
    check("rst_ram_we",  32'(ram_write_enable), 32'd0);
    check("rst_ram_addr", 32'(ram_address), 32'd0);
    check("rst_ram_wd",  32'(ram_write_data), 32'd0);

    // Read 0x0004 (word 2).
    req_a(1'b0, 16'h0004, 16'h0000);
    tick();
    check("rd_access_addr", 32'(ram_address), 32'h0004);
    check("rd_access_we",   32'(ram_write_enable), 32'd0);
    check("rd_access_ack",  32'(a_bus.ack), 32'd0);
    tick();
    check("rd_ack",   32'(a_bus.ack), 32'd1);
    check("rd_data",  32'(a_bus.read_data), 32'hBEEF);
    check("rd_err",   32'(a_bus.error), 32'd0);
    a_bus.request = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(a_bus.ack), 32'd0);
    check("rd_data_hold", 32'(a_bus.read_data), 32'hBEEF);

    // Write 0x1234 to 0x0010 (word 8); read data captures the old word.
    req_a(1'b1, 16'h0010, 16'h1234);
    tick();
    check("wr_we",   32'(ram_write_enable), 32'd1);
    check("wr_addr", 32'(ram_address), 32'h0010);
    check("wr_data", 32'(ram_write_data), 32'h1234);
    tick();
    check("wr_ack",   32'(a_bus.ack), 32'd1);
    check("wr_mem8",  32'(mem[8]), 32'h1234);
    check("wr_rdata_old", 32'(a_bus.read_data), 32'hAAAA);
    a_bus.request = 1'b0;
    tick();
    req_a(1'b0, 16'h0010, 16'h0000);
    tick();
    tick();
    check("rdback_ack",  32'(a_bus.ack), 32'd1);
    check("rdback_data", 32'(a_bus.read_data), 32'h1234);
    a_bus.request = 1'b0;

    // Both requesters held continuously after reset: A, B, A, B.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_a(1'b0, 16'h0004, 16'h0000);
    req_b(1'b0, 16'h0010, 16'h0000);
    a_pat = 8'b0010_0010;
    b_pat = 8'b1000_1000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("rr_a_ack_c%0d", c), 32'(a_bus.ack), 32'(a_pat[c-1]));
      check($sformatf("rr_b_ack_c%0d", c), 32'(b_bus.ack), 32'(b_pat[c-1]));
      if (a_pat[c-1]) check($sformatf("rr_a_data_c%0d", c), 32'(a_bus.read_data), 32'hBEEF);
      if (b_pat[c-1]) check($sformatf("rr_b_data_c%0d", c), 32'(b_bus.read_data), 32'h1234);
    end
    a_bus.request = 1'b0;
    b_bus.request = 1'b0;
    tick();
    tick();

    // Out of range: B writes 0x5555 to 0x0200.
    req_b(1'b1, 16'h0200, 16'h5555);
    tick();
    check("oor_addr", 32'(ram_address), 32'h0200);
    check("oor_we",   32'(ram_write_enable), 32'd0);
    tick();
    check("oor_ack",   32'(b_bus.ack), 32'd1);
    check("oor_err",   32'(b_bus.error), 32'd1);
    check("oor_rdata", 32'(b_bus.read_data), 32'd0);
    check("oor_mem0",  32'(mem[0]), 32'h0F0F);
    b_bus.request = 1'b0;
    tick();
    check("oor_err_pulse", 32'(b_bus.error), 32'd0);

    // A read moves the pointer to B before the aborted write.
    req_a(1'b0, 16'h0004, 16'h0000);
    tick();
    tick();
    check("pre_abort_ack", 32'(a_bus.ack), 32'd1);
    a_bus.request = 1'b0;
    tick();

    // Reset during ACCESS_A of a write to 0x0020 (word 16).
    req_a(1'b1, 16'h0020, 16'h9999);
    tick();
    check("abort_we_before", 32'(ram_write_enable), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_we_forced", 32'(ram_write_enable), 32'd0);
    tick();
    check("abort_no_ack", 32'(a_bus.ack), 32'd0);
    check("abort_mem16",  32'(mem[16]), 32'h7777);
    reset = 1'b1;
    a_bus.request = 1'b0;
    tick();
    check("abort_idle_ack", 32'(a_bus.ack), 32'd0);

    // Pointer back on A: a tie goes to A first.
    req_a(1'b0, 16'h0004, 16'h0000);
    req_b(1'b0, 16'h0010, 16'h0000);
    tick();
    tick();
    check("ptr_a_first_a", 32'(a_bus.ack), 32'd1);
    check("ptr_a_first_b", 32'(b_bus.ack), 32'd0);
    a_bus.request = 1'b0;
    tick();
    tick();
    check("ptr_then_b", 32'(b_bus.ack), 32'd1);
    b_bus.request = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter sharing the NBBPU's single-port data RAM (256 × 16-bit words, combinational read, write on rising clock edge, word index = address[15:1]). It sits between the RAM and two masters: requester A (CPU load/store path) and requester B (loader/debug port). It serialises accesses with a registered request/acknowledge handshake and round-robin fairness. It also rejects byte addresses outside the RAM.

## Interface
Parameters:
- DATA_WIDTH, 16, word width of all data buses
- ADDRESS_WIDTH, 16, byte-address width; RAM word index = address[ADDRESS_WIDTH-1:1]
- RAM_WORDS, 256, number of RAM words; valid byte addresses are 0x0000–0x01FF

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-low.
  - clock  in  1  system clock; all state changes on its rising edge
  - reset  in  1  synchronous active-low reset; sampled on the rising edge of clock
- Requester A (CPU load/store path):
  - a_request  in  1  A requests an access; held until a_ack
  - a_write_enable  in  1  1 = write, 0 = read
  - a_address  in  16  byte address
  - a_write_data  in  16  data to write
  - a_read_data  out  16  read result; valid while a_ack=1, then held
  - a_ack  out  1  one-cycle completion pulse
  - a_error  out  1  high with a_ack when the address was out of range
- Requester B (loader/debug port): b_request, b_write_enable, b_address, b_write_data, b_read_data, b_ack, b_error, identical to A
- RAM side:
  - ram_write_enable  out  1  RAM write strobe
  - ram_address  out  16  byte address to RAM
  - ram_write_data  out  16  data to RAM
  - ram_read_data  in  16  combinational RAM read data

## Operation
- State machine states are IDLE, ACCESS_A and ACCESS_B. Reset state is IDLE, with the priority pointer on A.
- In IDLE, eligible requests are considered:
  - A requester is eligible if its request=1 and its ack is not high this cycle. A request seen in its own ack cycle is ignored.
  - One eligible requester: it wins.
  - Both eligible: the requester named by the priority pointer wins.
  - The winner's write_enable, address and write_data are latched into internal registers, and the FSM moves to ACCESS_x.
- In ACCESS_x, the RAM is driven from the latched fields:
  - ram_address = latched address.
  - ram_write_enable = latched write_enable AND in_range AND reset.
  - in_range = (latched address[15:9] == 0).
  - On the exiting edge:
    - x_read_data ← in_range ? ram_read_data : 0 (captured for reads and writes alike).
    - x_ack ← 1.
    - x_error ← !in_range.
    - Priority pointer ← the other requester.
    - Next state = IDLE.
- Outside ACCESS states: ram_write_enable = 0, and ram_address/ram_write_data hold their last values.
- An out-of-range access performs no write, returns 0 and raises error.
- Address bit 0 is passed through unchanged, and the RAM ignores it.
- x_ack and x_error are high for exactly one cycle. x_read_data holds until the next ack for that requester.
- Requester contract: fields stay stable from request assertion until ack. After the ack, the requester drops its request or presents a new request from the cycle after ack.

## Timing
- Request first seen in IDLE at cycle N → ACCESS at N+1 → RAM write commits on the N+1→N+2 edge → ack, read_data and error visible in cycle N+2.
- Lone requester throughput: one access per 3 cycles.
- Alternating requesters: the other requester is granted during the ack cycle, giving one access per 2 cycles.
- Reset (reset=0 at an edge):
  - state ← IDLE, pointer ← A.
  - a/b_ack, a/b_error, a/b_read_data ← 0.
  - ram_address, ram_write_data ← 0.
- ram_write_enable is forced to 0 combinationally whenever reset=0, so a write in flight is abandoned and never committed. Its requester receives no ack and must re-request.

## Structure
- Shared header ram_arbiter_defs.vh contains:
  - state encodings (IDLE=2'd0, ACCESS_A=2'd1, ACCESS_B=2'd2)
  - RAM_WORDS and the in-range address limit
- One sub-module is natural: ram_arbiter_response. It holds one requester's read_data/ack/error registers and is instantiated twice.

## Test plan
- Read after reset: after reset release, A reads 0x0004 with RAM word 2 = 0xBEEF → a_ack in cycle N+2 with a_read_data=0xBEEF, a_error=0; all outputs are 0 before the request.
- Write then read: A writes 0x1234 to 0x0010, then reads 0x0010 → RAM word 8 = 0x1234 and the read returns 0x1234.
- Simultaneous requests, held continuously: A and B both request after reset → grant order A, B, A, B…; each ack is one cycle long; no double service occurs in an ack cycle.
- Out of range: B writes 0x5555 to 0x0200 → b_ack with b_error=1, b_read_data=0, ram_write_enable never high, RAM word 0 unchanged.
- Reset in ACCESS: A write to 0x0020 is in ACCESS_A when reset=0 → ram_write_enable=0 that cycle, RAM word 16 unchanged, no a_ack, state IDLE, pointer A.
